conv_requant_out: RTL

//  Post-processing stage directly downstream of the DSP-cascade convolution PE. Accepts the PE's
//  48-bit accumulator stream (P, valid strobe), adds a per-filter bias, rounds/shifts to output

---
 rtl/conv_pkg.sv | 23 ++
 rtl/out_fifo.sv | 45 ++++
 rtl/conv_requant_out.sv | 116 +++++++++++
 3 files changed

// File: rtl/conv_pkg.sv
// Shared constants and helpers for the convolution PE and its requantization stage.
package conv_pkg;

  localparam int ACC_WIDTH = 48;

  // One guard bit above the accumulator so bias addition cannot wrap.
  typedef logic signed [ACC_WIDTH:0] acc_ext_t;

  function automatic int out_dim(input int fm, input int k);
    return fm - k + 1;
  endfunction

  function automatic acc_ext_t sat_signed(input acc_ext_t value, input int width);
    acc_ext_t hi;
    acc_ext_t lo;
    hi = (acc_ext_t'(1) <<< (width - 1)) - acc_ext_t'(1);
    lo = -(acc_ext_t'(1) <<< (width - 1));
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/out_fifo.sv
// Synchronous first-word-fall-through FIFO; a write is accepted when full if a pop happens the same cycle.
module out_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_wr;
  logic             do_rd;

  assign o_empty = (wr_ptr_reg == rd_ptr_reg);
  assign o_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_rd   = i_rd && !o_empty;
  assign do_wr   = i_wr && (!o_full || do_rd);
  assign o_rdata = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (do_wr && !i_rst) mem[wr_ptr_reg[AW-1:0]] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/conv_requant_out.sv
// Bias, round, saturate and ReLU the PE accumulator stream, tag row/frame ends, and buffer toward the next layer.
module conv_requant_out
  import conv_pkg::*;
#(
  parameter int FM_SIZE     = 4,
  parameter int KERNEL_SIZE = 2,
  parameter int OUT_WIDTH   = 8,
  parameter int BIAS_WIDTH  = 32,
  parameter int SHIFT       = 8,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  logic signed [ACC_WIDTH-1:0] i_P,
  input  logic signed [BIAS_WIDTH-1:0] i_bias,
  input  logic                        i_relu,
  input  logic                        i_ready,
  output logic                        o_valid,
  output logic signed [OUT_WIDTH-1:0] o_data,
  output logic                        o_row_last,
  output logic                        o_last,
  output logic                        o_overflow
);

  localparam int OUT_DIM = out_dim(FM_SIZE, KERNEL_SIZE);
  localparam int CW      = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(OUT_DIM - 1);

  logic [CW-1:0] col_reg, row_reg;
  logic          s1_valid_reg, s1_row_last_reg, s1_last_reg;
  acc_ext_t      s1_sum_reg;
  logic          s2_valid_reg, s2_row_last_reg, s2_last_reg;
  acc_ext_t      s2_val_reg;
  logic          s3_valid_reg, s3_row_last_reg, s3_last_reg;
  logic signed [OUT_WIDTH-1:0] s3_data_reg;

  acc_ext_t                    round_val;
  logic signed [OUT_WIDTH-1:0] sat_val;
  logic signed [OUT_WIDTH-1:0] relu_val;
  logic [OUT_WIDTH+1:0]        fifo_rdata;
  logic                        fifo_empty, fifo_full, pop;

  // Counters advance on every accepted result, dropped or not, so tags stay aligned with the frame.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      col_reg <= '0;
      row_reg <= '0;
    end else if (i_en) begin
      if (col_reg == LAST_IDX) begin
        col_reg <= '0;
        row_reg <= (row_reg == LAST_IDX) ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  if (SHIFT > 0) begin : g_round
    localparam acc_ext_t HALF = acc_ext_t'(1) <<< (SHIFT - 1);
    assign round_val = (s1_sum_reg + HALF) >>> SHIFT;
  end else begin : g_no_round
    assign round_val = s1_sum_reg;
  end

  always_comb begin
    sat_val  = OUT_WIDTH'(sat_signed(s2_val_reg, OUT_WIDTH));
    relu_val = (i_relu && sat_val[OUT_WIDTH-1]) ? '0 : sat_val;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_valid_reg <= 1'b0; s1_row_last_reg <= 1'b0; s1_last_reg <= 1'b0; s1_sum_reg <= '0;
      s2_valid_reg <= 1'b0; s2_row_last_reg <= 1'b0; s2_last_reg <= 1'b0; s2_val_reg <= '0;
      s3_valid_reg <= 1'b0; s3_row_last_reg <= 1'b0; s3_last_reg <= 1'b0; s3_data_reg <= '0;
    end else begin
      s1_valid_reg    <= i_en;
      s1_sum_reg      <= acc_ext_t'(i_P) + acc_ext_t'(i_bias);
      s1_row_last_reg <= (col_reg == LAST_IDX);
      s1_last_reg     <= (col_reg == LAST_IDX) && (row_reg == LAST_IDX);
      s2_valid_reg    <= s1_valid_reg;
      s2_val_reg      <= round_val;
      s2_row_last_reg <= s1_row_last_reg;
      s2_last_reg     <= s1_last_reg;
      s3_valid_reg    <= s2_valid_reg;
      s3_data_reg     <= relu_val;
      s3_row_last_reg <= s2_row_last_reg;
      s3_last_reg     <= s2_last_reg;
    end
  end

  assign pop = o_valid && i_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) o_overflow <= 1'b0;
    else if (s3_valid_reg && fifo_full && !pop) o_overflow <= 1'b1;
  end

  out_fifo #(
    .WIDTH (OUT_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_out_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_wr    (s3_valid_reg),
    .i_wdata ({s3_row_last_reg, s3_last_reg, s3_data_reg}),
    .i_rd    (pop),
    .o_rdata (fifo_rdata),
    .o_empty (fifo_empty),
    .o_full  (fifo_full)
  );

  assign o_valid = !fifo_empty;
  assign {o_row_last, o_last, o_data} = o_valid ? fifo_rdata : '0;

endmodule
